// File: rtl/nec_ir_transmit.sv
// nec_ir_transmit: NEC IR frame serialiser with ~38 kHz carrier and repeat codes; ports iCLK/iRST_n, iDATA/iVALID/oREADY handshake, iREPEAT level, oIRDA/oENVELOPE/oDONE outputs
module nec_ir_transmit #(
  parameter int CLKS_PER_UNIT    = 28125,
  parameter int CLKS_PER_CARRIER = 1316,
  parameter int CARRIER_HIGH     = 439,
  parameter int FRAME_UNITS      = 192
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [31:0] iDATA,
  input  logic        iVALID,
  output logic        oREADY,
  input  logic        iREPEAT,
  output logic        oIRDA,
  output logic        oENVELOPE,
  output logic        oDONE
);
  localparam int UW = $clog2(CLKS_PER_UNIT + 1);
  localparam int CW = $clog2(CLKS_PER_CARRIER + 1);
  localparam int PW = $clog2(FRAME_UNITS + 1);
  localparam logic [UW-1:0] U_LAST = UW'(CLKS_PER_UNIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_CARRIER - 1);
  localparam logic [CW-1:0] C_HIGH = CW'(CARRIER_HIGH);
  localparam logic [PW-1:0] P_LAST = PW'(FRAME_UNITS - 1);
  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP, REP_MARK, REP_SPACE, REP_STOP
  } state_t;
  state_t        state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [4:0]    seg_q, seg_d, seg_len;
  logic [PW-1:0] period_q, period_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] car_q, car_d;
  logic          irda_q, env_q, done_q;
  logic          irda_d, mark_d, unit_end, seg_done;
  always_comb begin
    unit_end = unit_q == U_LAST;
    seg_len  = (state_q == LEAD_MARK || state_q == REP_MARK) ? 5'd16 :
               state_q == LEAD_SPACE ? 5'd8 :
               state_q == REP_SPACE ? 5'd4 :
               (state_q == BIT_SPACE && shift_q[0]) ? 5'd3 : 5'd1;
    // GAP ends on the frame period rather than its own length, so leaders are FRAME_UNITS apart
    seg_done = unit_end && (state_q == GAP ? period_q == P_LAST : seg_q == seg_len - 5'd1);
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    if (state_q == IDLE) begin
      if (iVALID) begin
        state_d = LEAD_MARK;
        shift_d = iDATA;
        bit_d   = '0;
      end
    end else if (seg_done) begin
      case (state_q)
        LEAD_MARK:  state_d = LEAD_SPACE;
        LEAD_SPACE: state_d = BIT_MARK;
        BIT_MARK:   state_d = BIT_SPACE;
        BIT_SPACE: begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 5'd1;
          state_d = bit_q == 5'd31 ? STOP_MARK : BIT_MARK;
        end
        STOP_MARK:  state_d = GAP;
        GAP:        state_d = iREPEAT ? REP_MARK : IDLE;
        REP_MARK:   state_d = REP_SPACE;
        REP_SPACE:  state_d = REP_STOP;
        REP_STOP:   state_d = GAP;
        default:    state_d = IDLE;
      endcase
    end
    unit_d   = (state_q == IDLE || unit_end) ? '0 : unit_q + UW'(1);
    seg_d    = (state_q == IDLE || seg_done) ? '0 : unit_end ? seg_q + 5'd1 : seg_q;
    period_d = (state_q == IDLE || (state_q == GAP && seg_done)) ? '0 :
               unit_end ? period_q + PW'(1) : period_q;
    mark_d   = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP};
    // marks are always preceded by a space, so a rising envelope restarts the carrier high
    car_d    = ((mark_d && !env_q) || car_q == C_LAST) ? '0 : car_q + CW'(1);
    irda_d   = mark_d && car_d < C_HIGH;
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      unit_q   <= '0;
      seg_q    <= '0;
      period_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      car_q    <= '0;
      irda_q   <= 1'b0;
      env_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      seg_q    <= seg_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      car_q    <= car_d;
      irda_q   <= irda_d;
      env_q    <= mark_d;
      done_q   <= seg_done && (state_q == STOP_MARK || state_q == REP_STOP);
    end
  end
  // done_q is registered one cycle late, so the pulse is re-timed onto the stop mark's last cycle
  assign oDONE     = seg_done && (state_q == STOP_MARK || state_q == REP_STOP) && !done_q;
  assign oREADY    = state_q == IDLE;
  assign oIRDA     = irda_q;
  assign oENVELOPE = env_q;
endmodule

// File: tb/tb_nec_ir_transmit.sv
// tb_nec_ir_transmit: directed table-driven bench for nec_ir_transmit with scaled-down timing
module tb_nec_ir_transmit;
  localparam int U = 8;
  localparam int C = 5;
  localparam int H = 2;
  localparam int F = 192;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        rep = 1'b0;
  logic [31:0] data = '0;
  logic        ready, irda, env, done;
  int checks = 0, errors = 0;
  int done_cnt = 0, car_err = 0, rdy_err = 0, age = 0;

  typedef struct {
    logic [31:0] code;
    int          units;
  } vec_t;
  vec_t v[6];

  nec_ir_transmit #(
    .CLKS_PER_UNIT(U), .CLKS_PER_CARRIER(C), .CARRIER_HIGH(H), .FRAME_UNITS(F)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iDATA(data), .iVALID(valid), .oREADY(ready),
    .iREPEAT(rep), .oIRDA(irda), .oENVELOPE(env), .oDONE(done)
  );

  always #5 clk = ~clk;

  // independent carrier model: within a mark, oIRDA is high for H of every C cycles starting high
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!env) begin
      if (irda) car_err++;
      age = 0;
    end else begin
      if (irda !== ((age % C) < H)) car_err++;
      if (ready) rdy_err++;
      age++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%h) expected=%0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run(input logic lvl, output int n);
    n = 0;
    while (env === lvl && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [31:0] d);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // decodes one data frame starting at its first leader cycle; returns at the first GAP cycle
  task automatic frame(output logic [31:0] code, output int tot, output int bad);
    int m, s;
    code = '0;
    run(1'b1, m);
    tot = m;
    bad = int'(m != 16 * U);
    run(1'b0, s);
    tot += s;
    bad += int'(s != 8 * U);
    for (int i = 0; i < 32; i++) begin
      run(1'b1, m);
      run(1'b0, s);
      bad += int'(m != U) + int'(s != U && s != 3 * U);
      code[i] = (s == 3 * U);
      tot += m + s;
    end
    run(1'b1, m);
    bad += int'(m != U);
    tot += m;
  endtask

  initial begin
    logic [31:0] code;
    int tot, bad, g, m, s, m2, d0, c0, cnt;
    v[0] = '{32'hEC13FF00, 121};
    v[1] = '{32'h00000000, 89};
    v[2] = '{32'hFFFFFFFF, 153};
    v[3] = '{32'h00000001, 91};
    v[4] = '{32'h80000000, 91};
    v[5] = '{32'hFA05FF00, 121};

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_env", 32'(env), 0);
    chk("reset_irda", 32'(irda), 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      cnt += int'(env || irda || done || !ready);
    end
    chk("idle_quiet", cnt, 0);

    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      c0 = car_err;
      send(v[k].code);
      chk("ready_drop", 32'(ready), 0);
      chk("latency_env", 32'(env), 1);
      frame(code, tot, bad);
      chk("loopback_code", code, v[k].code);
      chk("frame_cycles", tot, v[k].units * U);
      chk("segment_shape", bad, 0);
      wait_ready(g);
      chk("gap_cycles", g, (F - v[k].units) * U);
      chk("done_count", done_cnt - d0, 1);
      chk("carrier", car_err - c0, 0);
    end

    d0 = done_cnt;
    rep = 1'b1;
    send(32'hFA05FF00);
    frame(code, tot, bad);
    chk("rep_data_code", code, 32'hFA05FF00);
    run(1'b0, g);
    chk("rep_period0", tot + g, F * U);
    for (int r = 0; r < 2; r++) begin
      run(1'b1, m);
      if (r == 1) rep = 1'b0;
      run(1'b0, s);
      run(1'b1, m2);
      chk("rep_lead_mark", m, 16 * U);
      chk("rep_space", s, 4 * U);
      chk("rep_stop", m2, U);
      if (r == 0) begin
        run(1'b0, g);
        chk("rep_period1", m + s + m2 + g, F * U);
      end else begin
        wait_ready(g);
        chk("rep_last_period", m + s + m2 + g, F * U);
      end
    end
    chk("rep_done_count", done_cnt - d0, 3);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      cnt += int'(env);
    end
    chk("rep_stopped", cnt, 0);

    data  = 32'h12345678;
    valid = 1'b1;
    @(negedge clk);
    data = 32'h5A5A0F0F;
    chk("busy_ready", 32'(ready), 0);
    frame(code, tot, bad);
    chk("busy_code_a", code, 32'h12345678);
    chk("busy_frame_a", tot, 115 * U);
    wait_ready(g);
    chk("busy_gap_a", g, (F - 115) * U);
    @(negedge clk);
    valid = 1'b0;
    chk("busy_second_start", 32'(env), 1);
    frame(code, tot, bad);
    chk("busy_code_b", code, 32'h5A5A0F0F);
    chk("busy_shape_b", bad, 0);
    wait_ready(g);
    chk("busy_gap_b", g, (F - 121) * U);

    send(32'h00000000);
    run(1'b1, m);
    run(1'b0, s);
    run(1'b1, m);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_env", 32'(env), 0);
    chk("rst_irda", 32'(irda), 0);
    chk("rst_ready", 32'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    cnt = 0;
    repeat (2 * F * U) begin
      @(negedge clk);
      cnt += int'(env || irda || !ready);
    end
    chk("rst_no_resume", cnt, 0);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("ready_low_in_marks", rdy_err, 0);
    chk("carrier_total", car_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
